// File: rtl/seq_if.sv
// Sequencer bus: ROM fetch, ALU flags, datapath controls, start/busy/done.
// SEQ_STEP_EN adds the single-step input.
interface seq_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic [11:0]     instr;
  logic            alu_z;
  logic            alu_n;
  logic            alu_c;
`ifdef SEQ_STEP_EN
  logic            step;
`endif
  logic [PC_W-1:0] pc;
  logic            sa;
  logic [1:0]      sb;
  logic [7:0]      lit;
  logic [2:0]      alu_op;
  logic            la;
  logic            lb;
  logic            busy;
  logic            done;

  modport master (
    input  start, instr,
    input  alu_z, alu_n, alu_c,
`ifdef SEQ_STEP_EN
    input  step,
`endif
    output pc, sa, sb, lit, alu_op,
    output la, lb, busy, done
  );

  modport slave (
    output start, instr,
    output alu_z, alu_n, alu_c,
`ifdef SEQ_STEP_EN
    output step,
`endif
    input  pc, sa, sb, lit, alu_op,
    input  la, lb, busy, done
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC controller for the A/B datapath.
// SEQ_STEP_EN: park in WAIT after each instruction until step.
module datapath_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic   clk,
  input logic   reset,
  seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
`ifdef SEQ_STEP_EN
    , WAIT
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [11:0]     ir_q, ir_d;
  logic [2:0]      flags_q, flags_d;

  logic       sa, la, lb, take;
  logic [1:0] sb;
  logic [2:0] alu_op;
  logic [3:0] opc;
  logic       unused_c;

  assign opc      = ir_q[11:8];
  assign unused_c = flags_q[0];

  // Jumps only ever look at the flags latched by an earlier instruction
  always_comb begin
    take = 1'b0;
    unique case (opc)
      4'hB:    take = 1'b1;
      4'hC:    take = flags_q[2];
      4'hD:    take = !flags_q[2];
      4'hE:    take = flags_q[1];
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    sa      = 1'b0;
    sb      = 2'd0;
    alu_op  = 3'd0;
    la      = 1'b0;
    lb      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pc_d    = RESET_PC;
          state_d = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        ir_d    = bus.instr;
        state_d = EXEC;
      end
      EXEC: begin
        unique case (opc)
          4'h1: begin sa = 1'b1; la = 1'b1; end
          4'h2: begin sb = 2'd1; lb = 1'b1; end
          4'h3: begin
            sa = 1'b1; sb = 2'd2; la = 1'b1;
          end
          4'h4: begin
            sa = 1'b1; sb = 2'd2; lb = 1'b1;
          end
          4'h5: la = 1'b1;
          4'h6: begin alu_op = 3'd1; la = 1'b1; end
          4'h7: begin alu_op = 3'd2; la = 1'b1; end
          4'h8: begin alu_op = 3'd3; la = 1'b1; end
          4'h9: begin sb = 2'd2; la = 1'b1; end
          4'hA: alu_op = 3'd1;
          default: ;
        endcase
        if (opc >= 4'h5 && opc <= 4'hA)
          flags_d = {bus.alu_z, bus.alu_n, bus.alu_c};
        if (opc == 4'hF) begin
          state_d = HALT;
        end else begin
          pc_d = take ? PC_W'(ir_q[7:0])
                      : pc_q + PC_W'(1);
`ifdef SEQ_STEP_EN
          state_d = WAIT;
`else
          state_d = FETCH;
`endif
        end
      end
      HALT: state_d = IDLE;
`ifdef SEQ_STEP_EN
      WAIT: begin
        if (bus.step) state_d = FETCH;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.lit    = ir_q[7:0];
  assign bus.sa     = sa;
  assign bus.sb     = sb;
  assign bus.alu_op = alu_op;
  assign bus.la     = la;
  assign bus.lb     = lb;
  assign bus.done   = (state_q == HALT);
`ifdef SEQ_STEP_EN
  assign bus.busy   = (state_q == FETCH)
                   || (state_q == DECODE)
                   || (state_q == EXEC)
                   || (state_q == WAIT);
`else
  assign bus.busy   = (state_q == FETCH)
                   || (state_q == DECODE)
                   || (state_q == EXEC);
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a synchronous ROM model.
// Cycle 1 is the first cycle after the edge that samples start.
module tb_datapath_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic [11:0] rom [0:255];

  seq_if #(.PC_W(8)) bus ();

  datapath_sequencer #(
    .PC_W(8),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.instr <= rom[bus.pc];

  function automatic logic [7:0] ctl();
    return {bus.sa, bus.sb, bus.alu_op,
            bus.la, bus.lb};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.alu_z = 1'b0;
    bus.alu_n = 1'b0;
    bus.alu_c = 1'b0;
`ifdef SEQ_STEP_EN
    bus.step = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.pc, bus.busy, bus.done, ctl(), bus.lit}
        !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h busy=%b done=%b ctl=%h lit=%h, want all 0",
               bus.pc, bus.busy, bus.done, ctl(), bus.lit);
    end
    reset = 1'b0;
    clear_rom();
    rom[0] = 12'h305;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.la, bus.pc, bus.busy, bus.lit} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_mid_exec: la=%b pc=%h busy=%b lit=%h, want 0",
               bus.la, bus.pc, bus.busy, bus.lit);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.la, bus.busy, bus.pc} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_stays_idle: la=%b busy=%b pc=%h, want 0",
               bus.la, bus.busy, bus.pc);
    end
  endtask

  task automatic test_program();
    int n_la = 0, n_lb = 0, n_done = 0;
    clear_rom();
    rom[0] = 12'h305;
    rom[1] = 12'h403;
    rom[2] = 12'h500;
    rom[3] = 12'hF00;
    bus.start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      n_la += int'(bus.la);
      n_lb += int'(bus.lb);
      n_done += int'(bus.done);
      if (c == 3) begin
        vectors++;
        if (ctl() !== 8'hC2 || bus.lit !== 8'h05) begin
          miscompares++;
          $display("FAIL prog_mov_a_lit: ctl=%h lit=%h, want C2 05",
                   ctl(), bus.lit);
        end
      end
      if (c == 6) begin
        vectors++;
        if (ctl() !== 8'hC1 || bus.lit !== 8'h03) begin
          miscompares++;
          $display("FAIL prog_mov_b_lit: ctl=%h lit=%h, want C1 03",
                   ctl(), bus.lit);
        end
      end
      if (c == 9) begin
        vectors++;
        if (ctl() !== 8'h02) begin
          miscompares++;
          $display("FAIL prog_add: ctl=%h, want 02", ctl());
        end
      end
      if (c == 10) begin
        vectors++;
        if (bus.pc !== 8'h03 || bus.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL prog_fetch3: pc=%h busy=%b, want 03 1",
                   bus.pc, bus.busy);
        end
      end
      if (c == 13) begin
        vectors++;
        if (bus.done !== 1'b1 || bus.pc !== 8'h03
            || bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL prog_done: done=%b pc=%h busy=%b, want 1 03 0",
                   bus.done, bus.pc, bus.busy);
        end
      end
    end
    vectors++;
    if (n_la != 2 || n_lb != 1 || n_done != 1) begin
      miscompares++;
      $display("FAIL prog_pulse_count: la=%0d lb=%0d done=%0d, want 2 1 1",
               n_la, n_lb, n_done);
    end
  endtask

  task automatic test_decode();
    logic [7:0] exp_ctl [0:10];
    int bad_idle = 0;
    exp_ctl = '{8'h00, 8'h82, 8'h21, 8'hC2, 8'hC1,
                8'h02, 8'h06, 8'h0A, 8'h0E, 8'h42,
                8'h04};
    clear_rom();
    for (int i = 0; i <= 10; i++)
      rom[i] = {4'(i), 8'h50 + 8'(i)};
    rom[11] = 12'hF00;
    bus.start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c % 3 == 0 && c <= 33) begin
        vectors++;
        if (ctl() !== exp_ctl[c/3-1]
            || bus.lit !== 8'h50 + 8'(c/3-1)) begin
          miscompares++;
          $display("FAIL decode_op%0h: ctl=%h lit=%h, want %h %h",
                   c/3-1, ctl(), bus.lit, exp_ctl[c/3-1],
                   8'h50 + 8'(c/3-1));
        end
      end else if (ctl() !== 8'h00) begin
        bad_idle++;
      end
      if (c == 37) begin
        vectors++;
        if (bus.done !== 1'b1 || bus.pc !== 8'h0B) begin
          miscompares++;
          $display("FAIL decode_done: done=%b pc=%h, want 1 0b",
                   bus.done, bus.pc);
        end
      end
    end
    vectors++;
    if (bad_idle != 0) begin
      miscompares++;
      $display("FAIL decode_ctl_outside_exec: %0d cycles nonzero, want 0",
               bad_idle);
    end
  endtask

  task automatic test_branch(input logic [11:0] br,
                             input logic z, input logic n,
                             input logic [7:0] exp_pc,
                             input string name);
    clear_rom();
    rom[0] = 12'hA00;
    rom[1] = br;
    rom[2] = 12'hF00;
    rom[8'h40] = 12'hF00;
    bus.alu_z = z;
    bus.alu_n = n;
    bus.start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 4) begin
        bus.alu_z = !z;
        bus.alu_n = !n;
      end
      if (c == 7) begin
        vectors++;
        if (bus.pc !== exp_pc) begin
          miscompares++;
          $display("FAIL %s: pc=%h, want %h",
                   name, bus.pc, exp_pc);
        end
      end
      if (c == 10) begin
        vectors++;
        if (bus.done !== 1'b1 || bus.pc !== exp_pc) begin
          miscompares++;
          $display("FAIL %s_done: done=%b pc=%h, want 1 %h",
                   name, bus.done, bus.pc, exp_pc);
        end
      end
    end
    bus.alu_z = 1'b0;
    bus.alu_n = 1'b0;
  endtask

  task automatic test_flag_hold();
    clear_rom();
    rom[0] = 12'hA00;
    rom[1] = 12'h311;
    rom[2] = 12'hC40;
    rom[3] = 12'hF00;
    rom[8'h40] = 12'hF00;
    bus.alu_z = 1'b1;
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 4) bus.alu_z = 1'b0;
    end
    vectors++;
    if (bus.pc !== 8'h40) begin
      miscompares++;
      $display("FAIL flag_hold_mov: pc=%h, want 40", bus.pc);
    end
    do_reset();
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = 12'hBFF;
    rom[255] = 12'h000;
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 4 || c == 10) begin
        vectors++;
        if (bus.pc !== 8'hFF) begin
          miscompares++;
          $display("FAIL wrap_at_ff_c%0d: pc=%h, want ff",
                   c, bus.pc);
        end
      end
      if (c == 7) begin
        vectors++;
        if (bus.pc !== 8'h00) begin
          miscompares++;
          $display("FAIL wrap_to_00: pc=%h, want 00", bus.pc);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_start_while_busy();
    clear_rom();
    rom[0] = 12'h305;
    rom[1] = 12'h403;
    rom[2] = 12'h500;
    rom[3] = 12'hF00;
    bus.start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus.start = (c == 4 || c == 11 || c == 13);
      if (c == 7) begin
        vectors++;
        if (bus.pc !== 8'h02) begin
          miscompares++;
          $display("FAIL busy_start_pc: pc=%h, want 02", bus.pc);
        end
      end
      if (c == 13) begin
        vectors++;
        if (bus.done !== 1'b1 || bus.pc !== 8'h03) begin
          miscompares++;
          $display("FAIL busy_start_done: done=%b pc=%h, want 1 03",
                   bus.done, bus.pc);
        end
      end
      if (c == 15) begin
        vectors++;
        if (bus.busy !== 1'b0 || bus.pc !== 8'h03) begin
          miscompares++;
          $display("FAIL busy_start_idle: busy=%b pc=%h, want 0 03",
                   bus.busy, bus.pc);
        end
      end
    end
  endtask

`ifdef SEQ_STEP_EN
  task automatic test_step();
    clear_rom();
    rom[0] = 12'h500;
    rom[1] = 12'h901;
    rom[2] = 12'hF00;
    bus.step = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      bus.step = (c == 7 || c == 13);
      if (c == 3 || c == 10) begin
        vectors++;
        if (ctl() !== (c == 3 ? 8'h02 : 8'h42)) begin
          miscompares++;
          $display("FAIL step_exec_c%0d: ctl=%h", c, ctl());
        end
      end
      if ((c >= 4 && c <= 7) || (c >= 11 && c <= 13)) begin
        vectors++;
        if (ctl() !== 8'h00 || bus.busy !== 1'b1
            || bus.pc !== (c <= 7 ? 8'h01 : 8'h02)) begin
          miscompares++;
          $display("FAIL step_wait_c%0d: ctl=%h busy=%b pc=%h",
                   c, ctl(), bus.busy, bus.pc);
        end
      end
      if (c == 17) begin
        vectors++;
        if (bus.done !== 1'b1 || bus.pc !== 8'h02) begin
          miscompares++;
          $display("FAIL step_done: done=%b pc=%h, want 1 02",
                   bus.done, bus.pc);
        end
      end
      if (c == 18) begin
        vectors++;
        if (bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL step_idle: busy=%b, want 0", bus.busy);
        end
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.alu_z = 1'b0;
    bus.alu_n = 1'b0;
    bus.alu_c = 1'b0;
`ifdef SEQ_STEP_EN
    bus.step = 1'b0;
`endif
    clear_rom();
    test_reset();
    do_reset();
`ifdef SEQ_STEP_EN
    test_step();
    do_reset();
`else
    test_program();
    do_reset();
    test_decode();
    do_reset();
    test_branch(12'hC40, 1'b1, 1'b0, 8'h40, "jeq_taken");
    test_branch(12'hC40, 1'b0, 1'b0, 8'h02, "jeq_not");
    test_branch(12'hD40, 1'b0, 1'b0, 8'h40, "jne_taken");
    test_branch(12'hD40, 1'b1, 1'b0, 8'h02, "jne_not");
    test_branch(12'hE40, 1'b0, 1'b1, 8'h40, "jlt_taken");
    test_branch(12'hE40, 1'b0, 1'b0, 8'h02, "jlt_not");
    test_branch(12'hB40, 1'b0, 1'b0, 8'h40, "jmp");
    test_flag_hold();
    test_wrap();
    test_start_while_busy();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
